mag_packet_serializer: RTL and testbench
========================================

// Module: mag_packet_serializer
// PURPOSE
//  Downstream of the 10 Hz magnetometer packet source. Captures the 80-bit MAG_DATA word
//  (id byte, 24-bit timestamp, X/Y/Z) on each CLK_10HZ rising edge, re-timed into the CLK domain.
//  Emits it as a byte stream (sync, 10 payload bytes LSB-first, XOR checksum) over valid/ready.
//  The stream feeds the telemetry UART TX / downlink FIFO.
// PARAMETERS
//  SYNC_BYTE       8'hAA  frame-start marker, sent first in every frame
//  NUM_DATA_BYTES  10     payload bytes per frame; payload width = 8*NUM_DATA_BYTES
// PORTS
//  CLK          in   1   system clock; single clock domain for all logic
//  RESET        in   1   asynchronous, active-high reset
//  CLK_10HZ     in   1   packet-rate strobe, asynchronous to CLK; MAG_DATA changes on its rising edge
//  MAG_DATA     in   80  packet word; [7:0] id, [31:8] timestamp, [47:32] X, [63:48] Y, [79:64] Z
//  BYTE_READY   in   1   downstream can accept a byte this cycle
//  BYTE_OUT     out  8   current stream byte
//  BYTE_VALID   out  1   BYTE_OUT holds a valid byte
//  BUSY         out  1   frame in progress (state != IDLE)
//  FRAME_DONE   out  1   one-cycle pulse when the checksum byte is accepted
//  OVERRUN_CNT  out  8   count of dropped frames; saturates at 8'hFF
// BEHAVIOUR
//  Reset (async, RESET=1):
//   - BYTE_OUT=0, BYTE_VALID=0, BUSY=0, FRAME_DONE=0, OVERRUN_CNT=0.
//   - State=IDLE; synchronizer flops and capture register cleared.
//  Strobe sync:
//   - CLK_10HZ passes through 2 flops, then a rising-edge detect.
//   - Output is tick, a one-cycle pulse 2-3 CLK cycles after the raw edge.
//   - MAG_DATA is quasi-static (updates every 100 ms), so it is stable when sampled on tick.
//  Transfer rule: a byte transfers on a CLK edge where BYTE_VALID && BYTE_READY.
//   - While BYTE_VALID=1 and BYTE_READY=0, BYTE_OUT and BYTE_VALID hold unchanged.
//  FSM states: IDLE, SYNC, DATA, CHK.
//   - IDLE: on tick, latch MAG_DATA into cap_reg, clear chk=0 and idx=0, go to SYNC.
//     BYTE_VALID=1 with BYTE_OUT=SYNC_BYTE on the next cycle (1-cycle latency from tick).
//   - SYNC: on transfer, go to DATA. BYTE_OUT=cap_reg[7:0].
//   - DATA: BYTE_OUT=cap_reg[8*idx+:8].
//     On transfer: chk ^= byte, idx++. After idx=NUM_DATA_BYTES-1 transfers, go to CHK.
//   - CHK: BYTE_OUT=chk, the XOR of the payload bytes only; the sync byte is excluded.
//     On transfer: FRAME_DONE=1 for 1 cycle, BYTE_VALID=0, go to IDLE.
//  Overrun:
//   - A tick while state != IDLE drops the new packet; the frame in flight is unaffected.
//   - OVERRUN_CNT += 1, saturating at 255.
//   - Exception: a tick on the same cycle the CHK byte transfers is NOT an overrun.
//     The new packet is latched and the FSM goes directly to SYNC (no IDLE cycle).
//  Reset mid-frame: the frame is abandoned and outputs return to reset values.
//   - The next tick after reset deasserts starts a fresh frame with SYNC_BYTE.
//  Checksum width: 8-bit XOR; idx width = clog2(NUM_DATA_BYTES).
//  BYTE_VALID never drops without a transfer once asserted (except by reset).
// STRUCTURE
//  Package mag_pkg:
//   - constants SYNC_BYTE_DEF=8'hAA, MAG_PKT_BYTES=10, MAG_PKT_W=80
//   - FSM state encoding (IDLE=2'd0, SYNC=2'd1, DATA=2'd2, CHK=2'd3)
//  Sub-module strobe_sync_edge:
//   - 2-flop synchronizer plus rising-edge detect, async active-high reset.
//   - Ports CLK, RESET, ASYNC_IN, PULSE_OUT.
//  Top level: FSM, 80-bit capture register, byte mux, checksum accumulator, overrun counter.
// TESTING
//  1. Nominal frame: MAG_DATA={16'h0064,16'h0032,16'h0000,24'h000001,8'h4D}, BYTE_READY=1, one CLK_10HZ edge.
//     -> stream AA 4D 01 00 00 00 00 32 00 64 00 1A, then FRAME_DONE pulse, then BYTE_VALID=0.
//  2. Backpressure: as test 1, with BYTE_READY=0 for 5 cycles while the 3rd byte (01) is presented.
//     -> BYTE_OUT=01 and BYTE_VALID=1 stable for all 5 cycles; the full stream is otherwise identical.
//  3. Overrun: BYTE_READY=0 held, 3 CLK_10HZ edges after the first.
//     -> OVERRUN_CNT=3; BYTE_OUT stays AA.
//     Then force 260 ticks -> OVERRUN_CNT saturates at 8'hFF.
//  4. Back-to-back: align a tick with the CHK transfer cycle.
//     -> OVERRUN_CNT unchanged; next cycle BYTE_OUT=AA with the new payload; BUSY stays 1.
//  5. Reset mid-frame: assert RESET after the 5th byte transfers.
//     -> all outputs 0 immediately (async).
//     After release, the next tick produces a complete 12-byte frame starting AA.
//  6. Checksum sweep: 100 random MAG_DATA values, random BYTE_READY.
//     -> scoreboard matches byte order, and the checksum equals the XOR of the 10 payload bytes.

Source files
------------

// File: rtl/mag_pkg.sv
// Shared constants and FSM state type for the magnetometer packet serializer.
package mag_pkg;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hAA;
    localparam int unsigned MAG_PKT_BYTES = 10;
    localparam int unsigned MAG_PKT_W     = 8 * MAG_PKT_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } mag_state_e;
endpackage

// File: rtl/strobe_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe, followed by a rising-edge
// detector producing a single-cycle pulse in the CLK domain.
module strobe_sync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic ASYNC_IN,
    output logic PULSE_OUT
);
    // [0],[1] are the synchronizer pair; [2] is the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ASYNC_IN};
        end
    end

    assign PULSE_OUT = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/mag_packet_serializer.sv
// Captures the 10 Hz magnetometer packet word and streams it over valid/ready as
// sync byte, payload bytes LSB-first, and an XOR checksum of the payload.
module mag_packet_serializer
    import mag_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned NUM_DATA_BYTES = MAG_PKT_BYTES
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        CLK_10HZ,
    input  logic [8*NUM_DATA_BYTES-1:0] MAG_DATA,
    input  logic                        BYTE_READY,
    output logic [7:0]                  BYTE_OUT,
    output logic                        BYTE_VALID,
    output logic                        BUSY,
    output logic                        FRAME_DONE,
    output logic [7:0]                  OVERRUN_CNT
);
    localparam int unsigned PW    = 8 * NUM_DATA_BYTES;
    localparam int unsigned IDX_W = (NUM_DATA_BYTES > 1) ? $clog2(NUM_DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BYTES - 1);

    mag_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [PW-1:0]    cap_q, cap_d;
    logic [7:0]       bout_q, bout_d;
    logic             bvalid_q, bvalid_d;
    logic             fdone_q, fdone_d;
    logic [7:0]       ovr_q, ovr_d;
    logic             tick;
    logic             xfer;
    logic             start;
    logic             drop;

    function automatic logic [7:0] pick(input logic [PW-1:0] w, input logic [IDX_W-1:0] i);
        pick = '0;
        for (int unsigned k = 0; k < NUM_DATA_BYTES; k++) begin
            if (i == IDX_W'(k)) pick = w[8*k +: 8];
        end
    endfunction

    strobe_sync_edge u_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .ASYNC_IN  (CLK_10HZ),
        .PULSE_OUT (tick)
    );

    assign xfer = bvalid_q & BYTE_READY;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        cap_d    = cap_q;
        bout_d   = bout_q;
        bvalid_d = bvalid_q;
        fdone_d  = 1'b0;
        ovr_d    = ovr_q;
        start    = 1'b0;
        drop     = 1'b0;

        unique case (state_q)
            IDLE: start = tick;
            SYNC: begin
                drop = tick;
                if (xfer) begin
                    bout_d  = cap_q[7:0];
                    state_d = DATA;
                end
            end
            DATA: begin
                drop = tick;
                if (xfer) begin
                    chk_d = chk_q ^ bout_q;
                    if (idx_q == IDX_LAST) begin
                        bout_d  = chk_q ^ bout_q;
                        state_d = CHK;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        bout_d = pick(cap_q, idx_q + IDX_W'(1));
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    fdone_d  = 1'b1;
                    bvalid_d = 1'b0;
                    bout_d   = '0;
                    state_d  = IDLE;
                    // A tick landing on the checksum transfer chains straight into the next frame.
                    start    = tick;
                end else begin
                    drop = tick;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            cap_d    = MAG_DATA;
            chk_d    = '0;
            idx_d    = '0;
            bout_d   = SYNC_BYTE;
            bvalid_d = 1'b1;
            state_d  = SYNC;
        end

        if (drop && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            chk_q    <= '0;
            cap_q    <= '0;
            bout_q   <= '0;
            bvalid_q <= 1'b0;
            fdone_q  <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            chk_q    <= chk_d;
            cap_q    <= cap_d;
            bout_q   <= bout_d;
            bvalid_q <= bvalid_d;
            fdone_q  <= fdone_d;
            ovr_q    <= ovr_d;
        end
    end

    assign BYTE_OUT    = bout_q;
    assign BYTE_VALID  = bvalid_q;
    assign BUSY        = (state_q != IDLE);
    assign FRAME_DONE  = fdone_q;
    assign OVERRUN_CNT = ovr_q;
endmodule

// File: tb/tb_mag_packet_serializer.sv
// Self-checking bench for mag_packet_serializer: fixed vectors, hand-built
// corner sequences and a randomized sweep against a frame-level model.
module tb_mag_packet_serializer;
    logic        CLK;
    logic        RESET;
    logic        CLK_10HZ;
    logic [79:0] MAG_DATA;
    logic        BYTE_READY;
    logic [7:0]  BYTE_OUT;
    logic        BYTE_VALID;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [7:0]  OVERRUN_CNT;

    bit          rand_ready;
    logic        ready_forced;
    int          checks;
    int          errors;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [79:0] mag;
        logic [7:0]  chk;
    } vec_t;
    vec_t vt[4];

    localparam logic [79:0] NOMINAL = {16'h0064, 16'h0032, 16'h0000, 24'h000001, 8'h4D};

    mag_packet_serializer #(
        .SYNC_BYTE      (8'hAA),
        .NUM_DATA_BYTES (10)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLK_10HZ    (CLK_10HZ),
        .MAG_DATA    (MAG_DATA),
        .BYTE_READY  (BYTE_READY),
        .BYTE_OUT    (BYTE_OUT),
        .BYTE_VALID  (BYTE_VALID),
        .BUSY        (BUSY),
        .FRAME_DONE  (FRAME_DONE),
        .OVERRUN_CNT (OVERRUN_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Sole driver of BYTE_READY; updates 2 time units after each rising edge.
    initial begin
        BYTE_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            BYTE_READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_forced;
        end
    end

    // Byte accepted at the coming rising edge.
    always @(negedge CLK) begin
        if (BYTE_VALID && BYTE_READY) rx_q.push_back(BYTE_OUT);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_neg();
        @(negedge CLK);
        #1;
    endtask

    // Frame model: sync byte, payload bytes LSB-first, XOR of payload bytes.
    task automatic build_exp(input logic [79:0] mag, output logic [7:0] c);
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        c = 8'h00;
        for (int i = 0; i < 10; i++) begin
            b = mag[8*i +: 8];
            exp_q.push_back(b);
            c = c ^ b;
        end
        exp_q.push_back(c);
    endtask

    task automatic cmp_stream(input string nm);
        check($sformatf("%s_len", nm), 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size())
                check($sformatf("%s_byte%0d", nm, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic start_tick(input logic [79:0] mag);
        MAG_DATA = mag;
        rx_q.delete();
        CLK_10HZ = 1'b1;
    endtask

    task automatic finish_frame(input string nm);
        bit seen;
        seen = 1'b0;
        for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
            wait_neg();
            if (cyc == 4) CLK_10HZ = 1'b0;
            if (FRAME_DONE) seen = 1'b1;
        end
        CLK_10HZ = 1'b0;
        check($sformatf("%s_done", nm), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("%s_valid_low", nm), 32'(BYTE_VALID), 32'd0);
            check($sformatf("%s_busy_low", nm), 32'(BUSY), 32'd0);
        end
        cmp_stream(nm);
        repeat (4) wait_neg();
    endtask

    task automatic run_frame(input logic [79:0] mag, input string nm);
        logic [7:0] c;
        build_exp(mag, c);
        start_tick(mag);
        finish_frame(nm);
    endtask

    task automatic wait_rx(input int n, input string nm);
        bit ok;
        ok = 1'b0;
        for (int cyc = 0; cyc < 300 && !ok; cyc++) begin
            wait_neg();
            if (rx_q.size() >= n) ok = 1'b1;
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic pulse_10hz();
        CLK_10HZ = 1'b1;
        repeat (4) wait_neg();
        CLK_10HZ = 1'b0;
        repeat (4) wait_neg();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) wait_neg();
        RESET = 1'b0;
        repeat (2) wait_neg();
    endtask

    initial begin
        logic [7:0]  c;
        logic [7:0]  ovr0;
        logic [95:0] r;
        bit          ok;

        checks       = 0;
        errors       = 0;
        rand_ready   = 1'b0;
        ready_forced = 1'b1;
        RESET        = 1'b1;
        CLK_10HZ     = 1'b0;
        MAG_DATA     = '0;

        vt[0] = '{mag: NOMINAL,                    chk: 8'h1A};
        vt[1] = '{mag: 80'h0,                      chk: 8'h00};
        vt[2] = '{mag: {80{1'b1}},                 chk: 8'h00};
        vt[3] = '{mag: 80'h0A090807060504030201,   chk: 8'h0B};

        // Reset values
        repeat (2) wait_neg();
        check("rst_byte_out", 32'(BYTE_OUT), 32'd0);
        check("rst_valid", 32'(BYTE_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(FRAME_DONE), 32'd0);
        check("rst_ovr", 32'(OVERRUN_CNT), 32'd0);
        RESET = 1'b0;
        repeat (3) wait_neg();

        // Table-driven frames with full readiness
        for (int i = 0; i < 4; i++) begin
            run_frame(vt[i].mag, $sformatf("vec%0d", i));
            if (rx_q.size() == 12)
                check($sformatf("vec%0d_chk_const", i), 32'(rx_q[11]), 32'(vt[i].chk));
        end

        // Backpressure while the third byte is presented
        build_exp(NOMINAL, c);
        start_tick(NOMINAL);
        wait_rx(2, "bp_reach_byte2");
        ready_forced = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_neg();
            check($sformatf("bp_hold_byte_c%0d", k), 32'(BYTE_OUT), 32'h01);
            check($sformatf("bp_hold_valid_c%0d", k), 32'(BYTE_VALID), 32'd1);
        end
        ready_forced = 1'b1;
        finish_frame("bp");

        // Overrun counting and saturation
        do_reset();
        ready_forced = 1'b0;
        wait_neg();
        start_tick(NOMINAL);
        ok = 1'b0;
        for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
            wait_neg();
            if (BYTE_VALID) ok = 1'b1;
        end
        check("ovr_first_valid", 32'(ok), 32'd1);
        CLK_10HZ = 1'b0;
        repeat (4) wait_neg();
        repeat (3) pulse_10hz();
        check("ovr_cnt3", 32'(OVERRUN_CNT), 32'd3);
        check("ovr_byte_aa", 32'(BYTE_OUT), 32'hAA);
        check("ovr_valid", 32'(BYTE_VALID), 32'd1);
        check("ovr_busy", 32'(BUSY), 32'd1);
        repeat (260) pulse_10hz();
        check("ovr_sat", 32'(OVERRUN_CNT), 32'hFF);
        check("ovr_sat_byte_aa", 32'(BYTE_OUT), 32'hAA);
        do_reset();
        ready_forced = 1'b1;
        wait_neg();

        // Back-to-back: tick coincides with the checksum transfer
        build_exp(vt[3].mag, c);
        start_tick(vt[3].mag);
        wait_rx(11, "b2b_reach_last_data");
        ready_forced = 1'b0;
        CLK_10HZ = 1'b0;
        repeat (3) wait_neg();
        check("b2b_chk_presented", 32'(BYTE_OUT), 32'(c));
        ovr0 = OVERRUN_CNT;
        MAG_DATA = NOMINAL;
        CLK_10HZ = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1 ready_forced = 1'b1;
        @(posedge CLK);
        #1 ready_forced = 1'b0;
        wait_neg();
        check("b2b_done", 32'(FRAME_DONE), 32'd1);
        check("b2b_next_aa", 32'(BYTE_OUT), 32'hAA);
        check("b2b_valid", 32'(BYTE_VALID), 32'd1);
        check("b2b_busy", 32'(BUSY), 32'd1);
        check("b2b_ovr", 32'(OVERRUN_CNT), 32'(ovr0));
        cmp_stream("b2b_first");
        build_exp(NOMINAL, c);
        rx_q.delete();
        ready_forced = 1'b1;
        finish_frame("b2b_second");

        // Reset mid-frame after the fifth byte transfers
        start_tick(vt[3].mag);
        wait_rx(5, "mid_reach_byte5");
        CLK_10HZ = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        #1;
        check("mid_rst_byte", 32'(BYTE_OUT), 32'd0);
        check("mid_rst_valid", 32'(BYTE_VALID), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_done", 32'(FRAME_DONE), 32'd0);
        check("mid_rst_ovr", 32'(OVERRUN_CNT), 32'd0);
        repeat (2) wait_neg();
        RESET = 1'b0;
        repeat (3) wait_neg();
        run_frame(NOMINAL, "mid_restart");

        // Randomized sweep with random readiness
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            r = {$urandom, $urandom, $urandom};
            run_frame(r[79:0], $sformatf("rnd%0d", n));
        end
        rand_ready = 1'b0;
        check("rnd_no_overrun", 32'(OVERRUN_CNT), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
